uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter that replaces the fixed 8N1 transmitter.
- Configurable clock and baud rate, data width (5-9 bits), parity mode and stop-bit count.
- Adds a valid/ready input handshake so an upstream FIFO or controller can stream bytes back-to-back.
- Drives the board TX pin, plus an LED that toggles once per completed frame.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, truncating); must be >= 2.
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop-bit count: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  DATA_BITS  payload; sampled only on handshake.
- tx_valid  in  1  upstream has data.
- tx_ready  out  1  block can accept data this cycle.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- led  out  1  toggles at the end of each completed frame.

Behaviour:
- Reset (async assert, sync release): state IDLE, uart_tx=1, tx_ready=1, busy=0, led=0, baud counter=0, bit index=0.
- Handshake: a transfer occurs on a rising edge where tx_valid && tx_ready.
  - data is latched into a shift register on that edge.
  - A data change after the handshake has no effect on the frame in flight.
- tx_ready is combinationally equal to (state==IDLE). It never asserts mid-frame.
- State machine: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
- IDLE: uart_tx=1, busy=0. On handshake, go to START. uart_tx=0 from the next cycle, i.e. 1-cycle latency from the handshake edge to the start-bit edge.
- Bit timing: each bit holds for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, advances the state/bit at terminal count, then resets to 0.
- DATA: DATA_BITS bits, LSB first. Bit index runs 0..DATA_BITS-1.
- PARITY: one bit.
  - Odd mode: XOR of payload, inverted.
  - Even mode: XOR of payload.
  - Computed from the latched payload.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length in cycles: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
- At the final stop-bit terminal count: led toggles, busy drops, and the state returns to IDLE (tx_ready=1).
- Back-to-back: if tx_valid is held high, the next handshake happens on the first IDLE cycle. The next start bit then follows after exactly one IDLE cycle of uart_tx=1 beyond the stop period; no other gap.
- busy=1 from the cycle after the handshake through the last stop-bit cycle.
- Reset mid-frame: uart_tx goes to 1 immediately (async). The frame is aborted, led is cleared, and nothing is retransmitted after release.
- tx_valid asserted during reset: ignored. The first handshake is possible on the first clock edge after rst deasserts.
- uart_tx is driven from a register (glitch-free).

Test Plan:
- Defaults (CLKS_PER_BIT=434), data=8'h55, one valid pulse -> uart_tx: 0 for 434 cycles, then bits 1,0,1,0,1,0,1,0 each 434 cycles, then 1 for 434 cycles. busy high for 4340 cycles. led 0->1 at frame end. tx_ready low throughout.
- PARITY=2, data=8'h07 -> parity slot = 1 (three ones). PARITY=1, same data -> parity slot = 0. Frame = 11*434 cycles.
- STOP_BITS=2, DATA_BITS=7, data=7'h41 -> LSB-first bits 1,0,0,0,0,0,1. Stop high for 868 cycles. Total frame = 10*434 cycles.
- tx_valid held high with data 8'h55 then 8'hAA (changed mid-frame) -> first frame carries 0x55 unaffected. Second start bit begins one idle cycle after the first stop ends. led toggles twice.
- rst pulsed at cycle 2000 of a frame -> uart_tx=1 in the same cycle, busy=0, led=0, tx_ready=1. No residual bits after release. A new 8'hA5 frame then transmits correctly.
- Parameter CLK_FREQ=1_000_000, BAUD=250_000 (CLKS_PER_BIT=4) -> every bit period exactly 4 cycles, measured on each edge of the frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a valid/ready input handshake.
// Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits; led toggles per frame.
module uart_tx_frame #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 led
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 led_q, led_d;
  logic                 tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      led_q   <= led_d;
    end
  end

  assign tc = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    led_d   = led_q;
    tx_d    = 1'b1;

    if (state_q != S_IDLE) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_valid) begin
          shift_d = data;
          par_d   = (PARITY == 1) ? ~(^data) : (^data);
          state_d = S_START;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (tc) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        // bit_q counts stop bits here; the last terminal count closes the frame
        if (tc) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
            led_d   = ~led_q;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so uart_tx is glitch-free
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign uart_tx  = tx_q;
  assign led      = led_q;

endmodule
